// File: rtl/coin_input_conditioner.sv
// Coin/start switch front end for the parking meter core.
// Each raw switch is synchronised and debounced independently. A debounced
// rising edge on a coin channel latches a pending credit, and pending credits
// are handed to the meter over valid/ready, lowest channel first.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int VAL0            = 5,
  parameter int VAL1            = 10,
  parameter int VAL2            = 15,
  parameter int VAL_W           = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sw_coin,
  input  logic             sw_start,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic [VAL_W-1:0] coin_value,
  output logic             coin_drop,
  output logic             start_level,
  output logic             start_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Bit 3 is the start switch, bits 2:0 the coin channels.
  logic [3:0] raw;
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic [3:0] deb_p2;
  logic [3:0] deb_d_p2;
  logic [3:0] rise_p2;
  logic [2:0] pend_p3;
  logic [2:0] grant;
  logic [2:0] clr;

  // Seconds credited for the single channel selected by a one-hot grant.
  function automatic logic [VAL_W-1:0] credit_value(input logic [2:0] g);
    logic [VAL_W-1:0] v;
    v = '0;
    if (g[0])      v = VAL_W'(VAL0);
    else if (g[1]) v = VAL_W'(VAL1);
    else if (g[2]) v = VAL_W'(VAL2);
    return v;
  endfunction

  assign raw = {sw_start, sw_coin};

  // ---- stage p0/p1: two-flop synchroniser for all four raw switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-input debounce, accept a change once the counter has reached the limit
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync_p1[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync_p1[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign deb_p2[i] = deb_q;
  end

  assign rise_p2 = deb_p2 & ~deb_d_p2;

  // Lowest-index pending channel wins the handshake.
  always_comb begin
    grant = 3'b000;
    if (pend_p3[0])      grant = 3'b001;
    else if (pend_p3[1]) grant = 3'b010;
    else if (pend_p3[2]) grant = 3'b100;
  end

  assign clr = coin_ready ? grant : 3'b000;

  // ---- stage p3: edge detect, pending credits, drop and start pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_d_p2    <= '0;
      pend_p3     <= '0;
      coin_drop   <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      deb_d_p2    <= deb_p2;
      // A new press on the channel being transferred re-arms it (set wins).
      pend_p3     <= (pend_p3 & ~clr) | rise_p2[2:0];
      coin_drop   <= |(rise_p2[2:0] & pend_p3 & ~clr);
      start_pulse <= rise_p2[3];
    end
  end

  assign coin_valid  = |pend_p3;
  assign coin_value  = credit_value(grant);
  assign start_level = deb_p2[3];

endmodule
